uart_cmd_encoder: RTL
=====================

Name: uart_cmd_encoder

Overview:
Host-side initiator for the interferometer's nibble-oriented UART command protocol. It takes a staged configuration (integration time, sample time, active line, module enables) and a field mask, and serializes them into the command byte stream the correlator top decodes. The stream ends with a COMMIT byte. Bytes go out over a valid/ready handshake to a byte-wide UART transmitter. The block is used in the host/bridge FPGA and in the correlator regression bench as the command driver.

Parameters:
DATA_WIDTH, 64, width of each timing/line field; must be a multiple of 4
NIBBLES, DATA_WIDTH/4, nibbles sent per field (16 by default)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request; accepted only when busy=0
field_mask  in  4  bit0 integration_time, bit1 sample_time, bit2 active_line, bit3 enables
integration_time  in  DATA_WIDTH  value for opcode 1
sample_time  in  DATA_WIDTH  value for opcode 2
active_line  in  DATA_WIDTH  value for opcode 3
transmit_enable  in  1  enable bit (byte bit6)
integration_clock_enable  in  1  enable bit (byte bit5)
sample_clock_enable  in  1  enable bit (byte bit4)
tx_byte  out  8  command byte: [7:4] payload, [3:0] opcode
tx_valid  out  1  tx_byte is valid
tx_ready  in  1  UART transmitter accepts the byte when valid & ready
busy  out  1  sequence in progress
done  out  1  one-cycle pulse after the COMMIT byte is accepted
bytes_sent  out  8  bytes accepted in the current or last sequence

Behaviour:
- Reset values: tx_byte=0, tx_valid=0, busy=0, done=0, bytes_sent=0, FSM=IDLE.
- On start && !busy: latch all value inputs and field_mask into shadow registers, clear bytes_sent, set busy the next cycle. start while busy is ignored.
- Field order is fixed: integration (1), sample (2), active_line (3), enables (12), then COMMIT (13). Fields whose mask bit is 0 are skipped.
- For each masked timing/line field:
  - First send a RESET byte {id,4'h0}. This is required because it zeroes the receiver's nibble index. It also restores the receiver default, so every nibble must then be sent.
  - Then send NIBBLES bytes {value[4k+3:4k], id}, for k = 0..NIBBLES-1, LSB nibble first.
  - Leading-zero nibbles are never suppressed.
- Enables field: a single byte {1'b0, transmit_enable, integration_clock_enable, sample_clock_enable, 4'hC}.
- COMMIT is always sent as {4'h0, 4'hD}, even when field_mask=0.
- States: IDLE, SELECT (pick the next masked field or COMMIT), SEND_RESET, SEND_NIBBLE, SEND_ENABLE, SEND_COMMIT, DONE.
- SELECT takes 1 cycle. Each SEND state asserts tx_valid with tx_byte stable and holds both until tx_ready.
- Advance happens on the cycle of the valid && ready handshake. bytes_sent increments on every handshake.
- After the COMMIT handshake: DONE for 1 cycle (done=1, busy still 1), then IDLE with busy=0. A start is legal on the cycle after done.
- Nibble counter: log2(NIBBLES) bits; wraps to 0 when leaving a field.
- tx_ready may be held high permanently. Throughput is then one byte per cycle within a field, plus one SELECT cycle between fields.
- tx_ready while tx_valid=0 has no effect. tx_valid never drops without a handshake, except on reset.
- Byte counts:
  - Full mask: 3*(1+NIBBLES)+1+1 = 53 bytes (default).
  - Mask 0: 1 byte.
- Reset mid-sequence: all outputs go to reset values immediately and the partial stream is abandoned. Because COMMIT was not sent, the receiver's live configuration is unchanged. The next sequence starts each field with RESET, so a stale receiver nibble index is harmless.
- Input values changing while busy have no effect (shadow registers).

Decomposition:
- Shared package uart_cmd_pkg holds:
  - opcode constants: OP_RESET=0, OP_INTEGRATION_TIME=1, OP_SAMPLE_TIME=2, OP_ACTIVE_LINE=3, OP_ENABLE_MODULES=12, OP_COMMIT=13;
  - field_mask bit indices;
  - the FSM state enum.
- The correlator top's decoder shares the same opcode constants.
- No sub-module; the byte mux, nibble counter and FSM fit in one module.

Test Plan:
- Mask 4'b0000, tx_ready=1 -> exactly one byte 8'h0D, done pulses, bytes_sent=1.
- Mask 4'b0010, sample_time=64'h14, tx_ready=1 -> 17 bytes plus commit. Stream: 8'h20, 8'h42, 8'h12, then fourteen 8'h02, then 8'h0D. bytes_sent=18.
- Mask 4'b1000, enables {tx,int,smp}={1,0,1} -> bytes 8'h5C then 8'h0D.
- Mask 4'b1111, random values, tx_ready toggling randomly -> 53 bytes in order 1,2,3,12,13. tx_byte is stable while valid&&!ready. A loopback into the correlator top's decoder yields committed registers equal to the inputs.
- start asserted while busy, and inputs changed mid-sequence -> the second start is ignored and the stream reflects the latched values.
- reset asserted after 7 accepted bytes -> tx_valid=0, busy=0 the same cycle. A fresh start then produces a complete, correct stream beginning with a RESET byte.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Opcodes, field-mask bit positions and FSM states for the nibble-oriented UART
// command protocol. The correlator-side decoder uses the same opcode constants.
package uart_cmd_pkg;

   localparam logic [3:0] OP_RESET            = 4'h0;
   localparam logic [3:0] OP_INTEGRATION_TIME = 4'h1;
   localparam logic [3:0] OP_SAMPLE_TIME      = 4'h2;
   localparam logic [3:0] OP_ACTIVE_LINE      = 4'h3;
   localparam logic [3:0] OP_ENABLE_MODULES   = 4'hC;
   localparam logic [3:0] OP_COMMIT           = 4'hD;

   localparam int MASK_INTEGRATION = 0;
   localparam int MASK_SAMPLE      = 1;
   localparam int MASK_ACTIVE_LINE = 2;
   localparam int MASK_ENABLES     = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SELECT,
      ST_SEND_RESET,
      ST_SEND_NIBBLE,
      ST_SEND_ENABLE,
      ST_SEND_COMMIT,
      ST_DONE
   } state_t;

endpackage

// File: rtl/uart_cmd_encoder.sv
// Serializes a staged configuration into the UART command byte stream:
// per masked field a RESET byte plus every nibble LSB first, then enables, then COMMIT.
module uart_cmd_encoder
   import uart_cmd_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int NIBBLES    = DATA_WIDTH / 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [3:0]            field_mask,
   input  logic [DATA_WIDTH-1:0] integration_time,
   input  logic [DATA_WIDTH-1:0] sample_time,
   input  logic [DATA_WIDTH-1:0] active_line,
   input  logic                  transmit_enable,
   input  logic                  integration_clock_enable,
   input  logic                  sample_clock_enable,
   output logic [7:0]            tx_byte,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic                  busy,
   output logic                  done,
   output logic [7:0]            bytes_sent,
   output state_t                fsm_state
);

   localparam int NIB_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [NIB_W-1:0] NIB_LAST = NIB_W'(NIBBLES - 1);

   // Handshake: a byte transfers on a cycle where tx_valid && tx_ready. Once raised,
   // tx_valid and tx_byte stay constant until that transfer (only reset can drop them).
   logic                  hs;
   state_t                state;
   logic [3:0]            pend;
   logic [DATA_WIDTH-1:0] shd_int;
   logic [DATA_WIDTH-1:0] shd_smp;
   logic [DATA_WIDTH-1:0] shd_line;
   logic [2:0]            shd_en;
   logic [DATA_WIDTH-1:0] shift;
   logic [3:0]            cur_op;
   logic [NIB_W-1:0]      nib_cnt;

   assign hs        = tx_valid && tx_ready;
   assign fsm_state = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         tx_byte    <= 8'h00;
         tx_valid   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         bytes_sent <= 8'h00;
         pend       <= 4'h0;
         shd_int    <= '0;
         shd_smp    <= '0;
         shd_line   <= '0;
         shd_en     <= 3'b000;
         shift      <= '0;
         cur_op     <= OP_RESET;
         nib_cnt    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  shd_int    <= integration_time;
                  shd_smp    <= sample_time;
                  shd_line   <= active_line;
                  shd_en     <= {transmit_enable, integration_clock_enable, sample_clock_enable};
                  pend       <= field_mask;
                  bytes_sent <= 8'h00;
                  busy       <= 1'b1;
                  state      <= ST_SELECT;
               end
            end

            // Lowest pending mask bit wins, which gives the fixed field order.
            ST_SELECT: begin
               tx_valid <= 1'b1;
               if (pend[MASK_INTEGRATION]) begin
                  pend[MASK_INTEGRATION] <= 1'b0;
                  cur_op  <= OP_INTEGRATION_TIME;
                  shift   <= shd_int;
                  tx_byte <= {OP_INTEGRATION_TIME, OP_RESET};
                  state   <= ST_SEND_RESET;
               end else if (pend[MASK_SAMPLE]) begin
                  pend[MASK_SAMPLE] <= 1'b0;
                  cur_op  <= OP_SAMPLE_TIME;
                  shift   <= shd_smp;
                  tx_byte <= {OP_SAMPLE_TIME, OP_RESET};
                  state   <= ST_SEND_RESET;
               end else if (pend[MASK_ACTIVE_LINE]) begin
                  pend[MASK_ACTIVE_LINE] <= 1'b0;
                  cur_op  <= OP_ACTIVE_LINE;
                  shift   <= shd_line;
                  tx_byte <= {OP_ACTIVE_LINE, OP_RESET};
                  state   <= ST_SEND_RESET;
               end else if (pend[MASK_ENABLES]) begin
                  pend[MASK_ENABLES] <= 1'b0;
                  tx_byte <= {1'b0, shd_en, OP_ENABLE_MODULES};
                  state   <= ST_SEND_ENABLE;
               end else begin
                  tx_byte <= {4'h0, OP_COMMIT};
                  state   <= ST_SEND_COMMIT;
               end
            end

            ST_SEND_RESET: begin
               if (hs) begin
                  bytes_sent <= bytes_sent + 8'd1;
                  tx_byte    <= {shift[3:0], cur_op};
                  shift      <= shift >> 4;
                  nib_cnt    <= '0;
                  state      <= ST_SEND_NIBBLE;
               end
            end

            ST_SEND_NIBBLE: begin
               if (hs) begin
                  bytes_sent <= bytes_sent + 8'd1;
                  if (nib_cnt == NIB_LAST) begin
                     nib_cnt  <= '0;
                     tx_valid <= 1'b0;
                     state    <= ST_SELECT;
                  end else begin
                     nib_cnt <= nib_cnt + 1'b1;
                     tx_byte <= {shift[3:0], cur_op};
                     shift   <= shift >> 4;
                  end
               end
            end

            ST_SEND_ENABLE: begin
               if (hs) begin
                  bytes_sent <= bytes_sent + 8'd1;
                  tx_valid   <= 1'b0;
                  state      <= ST_SELECT;
               end
            end

            ST_SEND_COMMIT: begin
               if (hs) begin
                  bytes_sent <= bytes_sent + 8'd1;
                  tx_valid   <= 1'b0;
                  done       <= 1'b1;
                  state      <= ST_DONE;
               end
            end

            ST_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end

            default: begin
               tx_valid <= 1'b0;
               busy     <= 1'b0;
               done     <= 1'b0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
